// File: rtl/pong_playfield_if.sv
// pong_playfield_if: video timing in, colour/sync out, buttons and game status between controller and playfield.
interface pong_playfield_if #(
  parameter int ResolutionSize = 10
);
  logic [ResolutionSize-1:0] Xresolution, Yresolution, xpos, ypos;
  logic hsyncIn, vsyncIn, LeftUp, LeftDown, RightUp, RightDown;
  logic [7:0] rgb;
  logic hsync, vsync, FrameTick, GameOver;
  logic [3:0] ScoreLeft, ScoreRight;
  modport master (
    output Xresolution, Yresolution, xpos, ypos, hsyncIn, vsyncIn, LeftUp, LeftDown, RightUp, RightDown,
    input rgb, hsync, vsync, ScoreLeft, ScoreRight, FrameTick, GameOver
  );
  modport slave (
    input Xresolution, Yresolution, xpos, ypos, hsyncIn, vsyncIn, LeftUp, LeftDown, RightUp, RightDown,
    output rgb, hsync, vsync, ScoreLeft, ScoreRight, FrameTick, GameOver
  );
endinterface

// File: rtl/pong_playfield.sv
// pong_playfield: per-frame pong game state and one-clock-latency RRRGGGBB pixel generator.
module pong_playfield #(
  parameter int ResolutionSize = 10,
  parameter logic [ResolutionSize-1:0] PaddleHeight = 10'd80,
  parameter logic [ResolutionSize-1:0] PaddleWidth = 10'd8,
  parameter logic [ResolutionSize-1:0] BallSize = 10'd8,
  parameter logic [ResolutionSize-1:0] LeftPaddleX = 10'd16,
  parameter logic [ResolutionSize-1:0] RightPaddleX = 10'd616,
  parameter logic [ResolutionSize-1:0] PaddleStep = 10'd4,
  parameter logic [ResolutionSize-1:0] BallStep = 10'd2,
  parameter logic [5:0] ServeFrames = 6'd60
) (
  input logic clock,
  input logic reset,
  pong_playfield_if.slave bus
);
  localparam int W = ResolutionSize;
  localparam logic [W-1:0] one = 1;
  localparam logic [W-1:0] l_face = LeftPaddleX + PaddleWidth;
  typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAMEOVER} state_t;
  state_t state, state_n;
  logic [W-1:0] xres, yres, x, y, ypos_d, ly, ry, bx, by, ly_n, ry_n, bx_n, by_n, y_max, cx, cy;
  logic dx_right, dy_down, dx_n, dy_n, tick, frame_tick, hsync_q, vsync_q;
  logic l_ov, r_ov, l_hit, r_hit, in_ball, in_lp, in_rp, in_net, active;
  logic [5:0] hold_cnt, hold_n;
  logic [3:0] score_l, score_r, score_l_n, score_r_n;
  logic [7:0] pix, rgb_q;
  assign xres = bus.Xresolution;
  assign yres = bus.Yresolution;
  assign x = bus.xpos;
  assign y = bus.ypos;
  assign y_max = yres - PaddleHeight;
  assign cx = (xres - BallSize) >> 1;
  assign cy = (yres - BallSize) >> 1;
  assign tick = (y == yres) && (ypos_d != yres);
  function automatic logic [W-1:0] paddle_next(input logic [W-1:0] p, input logic up, input logic dn,
                                               input logic [W-1:0] lim);
    return (up && !dn) ? ((p >= PaddleStep) ? p - PaddleStep : '0)
         : (dn && !up) ? ((p + PaddleStep > lim) ? lim : p + PaddleStep) : p;
  endfunction
  // collisions look at the paddles as they stood before this tick
  assign l_ov = (by + BallSize > ly) && (by < ly + PaddleHeight);
  assign r_ov = (by + BallSize > ry) && (by < ry + PaddleHeight);
  assign l_hit = (bx <= l_face + BallStep) && (bx >= l_face) && l_ov;
  assign r_hit = (bx + BallStep + BallSize >= RightPaddleX) && (bx + BallSize <= RightPaddleX) && r_ov;
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    ly_n = ly;
    ry_n = ry;
    bx_n = bx;
    by_n = by;
    dx_n = dx_right;
    dy_n = dy_down;
    score_l_n = score_l;
    score_r_n = score_r;
    if (state == SERVE || state == PLAY) begin
      ly_n = paddle_next(ly, bus.LeftUp, bus.LeftDown, y_max);
      ry_n = paddle_next(ry, bus.RightUp, bus.RightDown, y_max);
    end
    if (state == SERVE) begin
      hold_n = (hold_cnt == ServeFrames - 6'd1) ? '0 : hold_cnt + 6'd1;
      state_n = (hold_cnt == ServeFrames - 6'd1) ? PLAY : SERVE;
    end
    if (state == PLAY) begin
      if (dy_down) begin
        by_n = (by + BallStep + BallSize >= yres) ? yres - BallSize : by + BallStep;
        dy_n = !(by + BallStep + BallSize >= yres);
      end else begin
        by_n = (by < BallStep) ? '0 : by - BallStep;
        dy_n = by < BallStep;
      end
      if (!dx_right) begin
        if (l_hit) begin
          bx_n = l_face;
          dx_n = 1'b1;
        end else if (bx < BallStep) begin
          score_r_n = score_r + 4'd1;
          state_n = SCORED;
        end else bx_n = bx - BallStep;
      end else begin
        if (r_hit) begin
          bx_n = RightPaddleX - BallSize;
          dx_n = 1'b0;
        end else if (bx + BallStep + BallSize >= xres) begin
          score_l_n = score_l + 4'd1;
          state_n = SCORED;
        end else bx_n = bx + BallStep;
      end
    end
    // a miss never flips dx, so it still points at the side that conceded
    if (state == SCORED) begin
      bx_n = cx;
      by_n = cy;
      dy_n = 1'b1;
      state_n = (score_l == 4'd9 || score_r == 4'd9) ? GAMEOVER : SERVE;
    end
  end
  assign active = (x < xres) && (y < yres);
  assign in_ball = (state != GAMEOVER) && (x >= bx) && (x < bx + BallSize) && (y >= by) && (y < by + BallSize);
  assign in_lp = (x >= LeftPaddleX) && (x < l_face) && (y >= ly) && (y < ly + PaddleHeight);
  assign in_rp = (x >= RightPaddleX) && (x < RightPaddleX + PaddleWidth) && (y >= ry) && (y < ry + PaddleHeight);
  assign in_net = ((x == (xres >> 1) - one) || (x == (xres >> 1))) && !y[4];
  assign pix = !active ? 8'h00 : in_ball ? 8'hFF : in_lp ? 8'h1C : in_rp ? 8'h03 : in_net ? 8'h92 : 8'h00;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SERVE;
      hold_cnt <= '0;
      ypos_d <= '0;
      ly <= y_max >> 1;
      ry <= y_max >> 1;
      bx <= cx;
      by <= cy;
      dx_right <= 1'b1;
      dy_down <= 1'b1;
      score_l <= '0;
      score_r <= '0;
      frame_tick <= 1'b0;
      rgb_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      ypos_d <= y;
      frame_tick <= tick;
      rgb_q <= pix;
      hsync_q <= bus.hsyncIn;
      vsync_q <= bus.vsyncIn;
      if (tick) begin
        state <= state_n;
        hold_cnt <= hold_n;
        ly <= ly_n;
        ry <= ry_n;
        bx <= bx_n;
        by <= by_n;
        dx_right <= dx_n;
        dy_down <= dy_n;
        score_l <= score_l_n;
        score_r <= score_r_n;
      end
    end
  end
  assign bus.rgb = rgb_q;
  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.FrameTick = frame_tick;
  assign bus.ScoreLeft = score_l;
  assign bus.ScoreRight = score_r;
  assign bus.GameOver = (score_l == 4'd9) || (score_r == 4'd9);
endmodule

// File: tb/tb_pong_playfield.sv
// tb_pong_playfield: directed game scenarios on a 640x480 field with hand-computed positions and scores.
module tb_pong_playfield;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  pong_playfield_if bus ();
  pong_playfield dut (.clock(clock), .reset(reset), .bus(bus));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      bus.ypos = 10'd0;
      @(posedge clock);
      #1;
      bus.ypos = 10'd480;
      @(posedge clock);
      #1;
    end
  endtask
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input int exp, input string tag);
    bus.xpos = x;
    bus.ypos = y;
    @(posedge clock);
    #1;
    check(tag, int'(bus.rgb), exp);
  endtask
  task automatic buttons(input logic lu, input logic ld, input logic ru, input logic rd);
    bus.LeftUp = lu;
    bus.LeftDown = ld;
    bus.RightUp = ru;
    bus.RightDown = rd;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.ypos = 10'd0;
    buttons(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  task automatic ball(input string tag, input int x, input int y);
    check({tag, "_bx"}, int'(dut.bx), x);
    check({tag, "_by"}, int'(dut.by), y);
  endtask
  initial begin
    bus.Xresolution = 10'd640;
    bus.Yresolution = 10'd480;
    bus.xpos = 10'd0;
    bus.ypos = 10'd0;
    bus.hsyncIn = 1'b1;
    bus.vsyncIn = 1'b1;
    buttons(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_rgb", int'(bus.rgb), 0);
    check("rst_hsync", int'(bus.hsync), 1);
    check("rst_vsync", int'(bus.vsync), 1);
    check("rst_tick", int'(bus.FrameTick), 0);
    check("rst_scores", int'({bus.ScoreLeft, bus.ScoreRight}), 0);
    check("rst_over", int'(bus.GameOver), 0);
    check("rst_ly", int'(dut.ly), 200);
    check("rst_ry", int'(dut.ry), 200);
    ball("rst", 316, 236);
    check("rst_dir", int'({dut.dx_right, dut.dy_down}), 3);
    check("rst_state", int'(dut.state), 0);
    reset = 1'b0;
    pix(316, 236, 8'hFF, "px_ball_tl");
    pix(323, 243, 8'hFF, "px_ball_br");
    pix(324, 236, 8'h00, "px_ball_right_edge");
    pix(315, 236, 8'h00, "px_ball_left_edge");
    pix(640, 0, 8'h00, "px_outside");
    pix(319, 0, 8'h92, "px_net");
    pix(320, 16, 8'h00, "px_net_gap");
    bus.hsyncIn = 1'b0;
    @(posedge clock);
    #1;
    check("hsync_delay", int'(bus.hsync), 0);
    bus.hsyncIn = 1'b1;
    ticks(59);
    check("serve59_state", int'(dut.state), 0);
    ball("serve59", 316, 236);
    ticks(1);
    check("serve60_state", int'(dut.state), 1);
    check("frametick_hi", int'(bus.FrameTick), 1);
    @(posedge clock);
    #1;
    check("frametick_lo", int'(bus.FrameTick), 0);
    ball("serve60", 316, 236);
    ticks(1);
    ball("play1", 318, 238);
    ticks(116);
    ball("play117", 550, 470);
    check("play117_dy", int'(dut.dy_down), 1);
    ticks(1);
    ball("floor", 552, 472);
    check("floor_dy", int'(dut.dy_down), 0);
    ticks(1);
    ball("floor_up", 554, 470);
    ticks(38);
    ball("play157", 630, 394);
    check("play157_state", int'(dut.state), 1);
    ticks(1);
    check("rmiss_score", int'(bus.ScoreLeft), 1);
    check("rmiss_state", int'(dut.state), 2);
    ticks(1);
    ball("rmiss_centre", 316, 236);
    check("rmiss_serve", int'(dut.state), 0);
    check("rmiss_dir", int'({dut.dx_right, dut.dy_down}), 3);
    do_reset();
    buttons(1, 0, 0, 1);
    ticks(50);
    check("clamp_ly", int'(dut.ly), 0);
    check("clamp_ry", int'(dut.ry), 400);
    ticks(1);
    check("clamp_ly51", int'(dut.ly), 0);
    check("clamp_ry51", int'(dut.ry), 400);
    buttons(1, 1, 1, 1);
    ticks(1);
    check("both_ly", int'(dut.ly), 0);
    check("both_ry", int'(dut.ry), 400);
    buttons(0, 0, 0, 0);
    check("clamp_state", int'(dut.state), 0);
    pix(16, 0, 8'h1C, "px_lpad");
    pix(24, 0, 8'h00, "px_lpad_edge");
    pix(623, 479, 8'h03, "px_rpad");
    pix(616, 399, 8'h00, "px_rpad_edge");
    do_reset();
    buttons(1, 0, 0, 1);
    ticks(20);
    buttons(0, 0, 0, 1);
    ticks(30);
    buttons(0, 0, 0, 0);
    ticks(10);
    check("hit_ly", int'(dut.ly), 120);
    check("hit_state", int'(dut.state), 1);
    ticks(146);
    ball("rhit", 608, 416);
    check("rhit_dir", int'({dut.dx_right, dut.dy_down}), 0);
    ticks(291);
    ball("lhit_pre", 26, 164);
    check("lhit_pre_dx", int'(dut.dx_right), 0);
    ticks(1);
    ball("lhit", 24, 166);
    check("lhit_dx", int'(dut.dx_right), 1);
    do_reset();
    buttons(0, 0, 0, 1);
    ticks(50);
    buttons(0, 0, 0, 0);
    ticks(10);
    ticks(450);
    ball("lmiss_pre", 0, 190);
    check("lmiss_pre_score", int'(bus.ScoreRight), 0);
    ticks(1);
    check("lmiss_score", int'(bus.ScoreRight), 1);
    check("lmiss_state", int'(dut.state), 2);
    ticks(1);
    ball("lmiss_centre", 316, 236);
    check("lmiss_dir", int'({dut.dx_right, dut.dy_down}), 1);
    check("lmiss_serve", int'(dut.state), 0);
    do_reset();
    ticks(1969);
    check("go_pre_score", int'(bus.ScoreLeft), 8);
    check("go_pre_over", int'(bus.GameOver), 0);
    ticks(1);
    check("go_score", int'(bus.ScoreLeft), 9);
    check("go_over", int'(bus.GameOver), 1);
    check("go_scored", int'(dut.state), 2);
    ticks(1);
    check("go_state", int'(dut.state), 3);
    ball("go_centre", 316, 236);
    pix(316, 236, 8'h00, "px_go_noball");
    buttons(1, 0, 0, 0);
    ticks(5);
    buttons(0, 0, 0, 0);
    check("go_hold_ly", int'(dut.ly), 200);
    check("go_hold_score", int'({bus.ScoreLeft, bus.ScoreRight}), 9 << 4);
    check("go_hold_state", int'(dut.state), 3);
    ball("go_hold", 316, 236);
    bus.ypos = 10'd0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.ypos = 10'd480;
    @(posedge clock);
    #1;
    check("rst_prio_state", int'(dut.state), 0);
    check("rst_prio_scores", int'({bus.ScoreLeft, bus.ScoreRight}), 0);
    check("rst_prio_over", int'(bus.GameOver), 0);
    check("rst_prio_tick", int'(bus.FrameTick), 0);
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
